booth_mult_seq: RTL and testbench
=================================

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 The block SHALL have parameter N, default 28, meaning multiplicand width in bits, signed two's complement, N >= 4.
REQ-002 The block SHALL have parameter M, default 16, meaning multiplier width in bits, signed two's complement, even, M >= 4.
REQ-003 The block SHALL have parameter G, default 1, meaning radix-4 Booth groups retired per cycle; M/2 SHALL be divisible by G.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands are valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-008 The block SHALL have port in_b, input, N bits: signed multiplicand.
REQ-009 The block SHALL have port in_a, input, M bits: signed multiplier, Booth-recoded.
REQ-010 The block SHALL have port out_valid, output, 1 bit: product is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the product.
REQ-012 The block SHALL have port out_p, output, N+M bits: signed product.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in BUSY state.

Function
REQ-014 The block SHALL implement the states IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; an input transfer SHALL occur on a clock edge with in_valid && in_ready.
REQ-016 On transfer the block SHALL latch in_b sign-extended to N+M bits, latch in_a with an appended LSB 0 (M+1 bits), clear the accumulator, clear the group counter, and enter BUSY.
REQ-017 Each BUSY cycle SHALL retire G consecutive 3-bit groups, starting at the LSB. Group i = a[2i+1:2i-1] SHALL be encoded as: 000/111 -> 0; 001/010 -> +b; 011 -> +2b; 100 -> -2b; 101/110 -> -b. Each term SHALL be weighted by 4^i and added to the accumulator modulo 2^(N+M).
REQ-018 BUSY SHALL last exactly M/(2G) cycles. After the last one the state SHALL become DONE, out_valid SHALL be 1 and out_p SHALL equal in_a*in_b exactly. No overflow is possible, because the full (N+M)-bit result range covers every operand pair.
REQ-019 In DONE, out_p SHALL be held stable until out_valid && out_ready. The state SHALL then return to IDLE on that edge, with out_valid 0 in the next cycle.
REQ-020 Throughput SHALL be one product per M/(2G)+2 cycles when out_ready is held at 1. The cycles are: accept in IDLE, M/(2G) cycles of BUSY, one cycle of DONE.
REQ-021 in_valid asserted during BUSY or DONE SHALL be ignored and SHALL NOT corrupt the operation in flight.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 Negative-most operands (b = -2^(N-1), a = -2^(M-1)) SHALL produce the correct positive product 2^(N+M-2).
REQ-024 Intermediate partial-product terms SHALL be N+2 bits signed before weighting; the -2b term SHALL NOT truncate at b = -2^(N-1).

Reset
REQ-025 While rst_n = 0, all of the following SHALL hold immediately, independent of clk: state = IDLE, in_ready = 1 (effective on rst_n release), out_valid = 0, busy = 0, out_p = 0, accumulator = 0, group counter = 0.
REQ-026 rst_n asserted mid-BUSY or in DONE SHALL abort the operation. No out_valid SHALL follow, and the first transfer after release SHALL compute correctly.

Verification
REQ-027 With N=28, M=16, G=1: b = -3, a = 5 -> busy for 8 cycles, then out_valid = 1 and out_p = -15 (44-bit two's complement).
REQ-028 With b = -2^27, a = -2^15 -> out_p = 2^42. Also b = -2^27, a = 2^15-1 -> out_p = -2^27*(2^15-1).
REQ-029 With G=2 and G=8, for 1000 random operand pairs -> out_p matches the reference product. Latency is 4 and 1 BUSY cycles respectively.
REQ-030 Hold out_ready = 0 for 5 cycles in DONE -> out_p stable and in_ready = 0 throughout. Toggle in_valid with new operands during BUSY -> result unchanged.
REQ-031 Pulse rst_n low at the 4th BUSY cycle -> out_valid stays 0. A subsequent b = 7, a = -6 -> out_p = -42.
REQ-032 Back-to-back stream with in_valid = out_ready = 1 -> a new transfer every 10 cycles (G=1), results in order.

Source files
------------

// File: rtl/booth_mult_seq_if.sv
// Operand/product handshake bundle for the sequential radix-4 Booth multiplier.
// The master drives operands and out_ready; the slave (the multiplier) answers.
interface booth_mult_seq_if #(
  parameter int N = 28,
  parameter int M = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_b;
  logic [M-1:0]     in_a;
  logic             out_valid;
  logic             out_ready;
  logic [N+M-1:0]   out_p;
  logic             busy;

  modport master (
    output in_valid, in_b, in_a, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_b, in_a, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier: radix-4 Booth recoding of in_a, G groups retired
// per BUSY cycle, full-width (N+M) product held in DONE until downstream takes it.
module booth_mult_seq #(
  parameter int N = 28,
  parameter int M = 16,
  parameter int G = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_mult_seq_if.slave bus
);
  localparam int W  = N + M;
  localparam int NC = M / (2 * G);
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int IW = $clog2(M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [W-1:0]    b_r;
  logic [M:0]      a_r;
  logic [W-1:0]    acc_r;
  logic [W-1:0]    acc_s;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    p_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;
  logic            last_s;
  logic [IW-1:0]   idx_s  [G];
  logic [N+1:0]    pp_s   [G];
  logic [W-1:0]    term_s [G];

  // Recode one 3-bit group into an N+2 bit signed term; the extra two bits
  // keep -2b exact when b is the most negative multiplicand.
  function automatic logic [N+1:0] booth_pp(input logic [2:0] grp, input logic [N-1:0] b);
    logic [N+1:0] b1;
    logic [N+1:0] b2;
    b1 = {{2{b[N-1]}}, b};
    b2 = {b[N-1], b, 1'b0};
    case (grp)
      3'b001, 3'b010: booth_pp = b1;
      3'b011:         booth_pp = b2;
      3'b100:         booth_pp = -b2;
      3'b101, 3'b110: booth_pp = -b1;
      default:        booth_pp = {(N+2){1'b0}};
    endcase
  endfunction

  assign last_s = (cnt_r == CW'(NC - 1));

  // Partial products for the G groups retired this cycle, weighted by 4^i.
  always_comb begin
    acc_s = acc_r;
    for (int g = 0; g < G; g++) begin
      idx_s[g]  = IW'(cnt_r) * IW'(G) + IW'(g);
      pp_s[g]   = booth_pp(a_r[{idx_s[g], 1'b0} +: 3], b_r[N-1:0]);
      term_s[g] = {{(M-2){pp_s[g][N+1]}}, pp_s[g]} << {idx_s[g], 1'b0};
      acc_s     = acc_s + term_s[g];
    end
  end

  // Next-state decode for the IDLE/BUSY/DONE handshake sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with registered status flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s == BUSY);
    end
  end

  // Operand capture, accumulation and product hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_r   <= {W{1'b0}};
      a_r   <= {(M+1){1'b0}};
      acc_r <= {W{1'b0}};
      cnt_r <= {CW{1'b0}};
      p_r   <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            b_r   <= {{M{bus.in_b[N-1]}}, bus.in_b};
            a_r   <= {bus.in_a, 1'b0};
            acc_r <= {W{1'b0}};
            cnt_r <= {CW{1'b0}};
          end
        end
        BUSY: begin
          acc_r <= acc_s;
          if (last_s) begin
            p_r <= acc_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          p_r <= p_r;
        end
        default: begin
          acc_r <= {W{1'b0}};
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out_p     = p_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: directed G=1 sequence plus random G=2 and
// G=8 instances sharing one clock and reset.
module tb_booth_mult_seq;
  localparam int N = 28;
  localparam int M = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.N(N), .M(M)) i1 ();
  booth_mult_seq_if #(.N(N), .M(M)) i2 ();
  booth_mult_seq_if #(.N(N), .M(M)) i8 ();

  booth_mult_seq #(.N(N), .M(M), .G(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  booth_mult_seq #(.N(N), .M(M), .G(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  booth_mult_seq #(.N(N), .M(M), .G(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));

  int errors = 0;
  int checks = 0;
  logic [43:0] q1[$];
  logic [43:0] q2[$];
  logic [43:0] q8[$];

  task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [43:0] ref_mul(input logic [27:0] b, input logic [15:0] a);
    logic signed [27:0] bs;
    logic signed [15:0] as;
    logic signed [43:0] r;
    bs = b;
    as = a;
    r  = bs * as;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start1(input logic [27:0] b, input logic [15:0] a, input logic [43:0] exp);
    chk("idle_ready", 44'(i1.in_ready), 44'd1);
    i1.in_b     = b;
    i1.in_a     = a;
    i1.in_valid = 1'b1;
    q1.push_back(exp);
    step();
    i1.in_valid = 1'b0;
  endtask

  task automatic finish1(input int exp_busy, input bit toggle, input int hold);
    int nb;
    int n;
    logic [31:0] t;
    logic [43:0] exp;
    nb = 0;
    n  = 0;
    while (i1.out_valid !== 1'b1 && n < 40) begin
      if (i1.busy === 1'b1) nb++;
      if (toggle) begin
        t            = $urandom;
        i1.in_valid  = ~i1.in_valid;
        i1.out_ready = ~i1.out_ready;
        i1.in_b      = t[27:0];
        i1.in_a      = t[31:16];
      end
      step();
      n++;
    end
    i1.in_valid  = 1'b0;
    i1.out_ready = 1'b0;
    chk("done_valid", 44'(i1.out_valid), 44'd1);
    chk("busy_cycles", 44'(nb), 44'(exp_busy));
    if (q1.size() > 0) exp = q1.pop_front();
    else exp = 44'h0;
    chk("product", i1.out_p, exp);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_p", i1.out_p, exp);
      chk("hold_in_ready", 44'(i1.in_ready), 44'd0);
      chk("hold_valid", 44'(i1.out_valid), 44'd1);
    end
    i1.out_ready = 1'b1;
    step();
    i1.out_ready = 1'b0;
    chk("ret_valid", 44'(i1.out_valid), 44'd0);
    chk("ret_in_ready", 44'(i1.in_ready), 44'd1);
  endtask

  initial begin
    logic [27:0] bb[5];
    logic [15:0] aa[5];
    logic [31:0] t;
    logic [27:0] rb;
    logic [15:0] ra;
    logic [43:0] e;
    int k;
    int got;
    int last_t;
    bit adv;

    rst_n = 1'b1;
    i1.in_valid = 1'b0; i1.out_ready = 1'b0; i1.in_b = 28'd0; i1.in_a = 16'd0;
    i2.in_valid = 1'b0; i2.out_ready = 1'b1; i2.in_b = 28'd0; i2.in_a = 16'd0;
    i8.in_valid = 1'b0; i8.out_ready = 1'b1; i8.in_b = 28'd0; i8.in_a = 16'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 44'(i1.in_ready), 44'd1);
    chk("rst_out_valid", 44'(i1.out_valid), 44'd0);
    chk("rst_busy", 44'(i1.busy), 44'd0);
    chk("rst_out_p", i1.out_p, 44'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Small signed product, result held 5 cycles in DONE.
    start1(28'hFFFFFFD, 16'd5, 44'hFFF_FFFF_FFF1);
    finish1(8, 1'b0, 5);
    // Most-negative operands with noise on in_valid/out_ready while busy.
    start1(28'h8000000, 16'h8000, 44'h400_0000_0000);
    finish1(8, 1'b1, 0);
    start1(28'h8000000, 16'h7FFF, ref_mul(28'h8000000, 16'h7FFF));
    finish1(8, 1'b1, 2);
    start1(28'h7FFFFFF, 16'h7FFF, ref_mul(28'h7FFFFFF, 16'h7FFF));
    finish1(8, 1'b0, 0);
    start1(28'h1234567, 16'd0, 44'd0);
    finish1(8, 1'b0, 0);
    for (int j = 0; j < 12; j++) begin
      t  = $urandom;
      rb = t[27:0];
      t  = $urandom;
      ra = t[15:0];
      start1(rb, ra, ref_mul(rb, ra));
      finish1(8, 1'b1, 0);
    end

    // Reset pulse on the 4th BUSY cycle aborts the operation.
    i1.in_b = 28'd100; i1.in_a = 16'd3; i1.in_valid = 1'b1;
    step();
    i1.in_valid = 1'b0;
    repeat (3) step();
    chk("abort_busy_before", 44'(i1.busy), 44'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 44'(i1.busy), 44'd0);
    chk("abort_in_ready", 44'(i1.in_ready), 44'd1);
    chk("abort_out_p", i1.out_p, 44'd0);
    #2 rst_n = 1'b1;
    step();
    for (int c = 0; c < 12; c++) begin
      chk("abort_no_valid", 44'(i1.out_valid), 44'd0);
      step();
    end
    start1(28'd7, 16'hFFFA, 44'hFFF_FFFF_FFD6);
    finish1(8, 1'b0, 0);

    // Back-to-back stream: one transfer every 10 cycles, results in order.
    for (int j = 0; j < 5; j++) begin
      t = $urandom;
      bb[j] = t[27:0];
      t = $urandom;
      aa[j] = t[15:0];
    end
    k = 0; got = 0; last_t = -1; adv = 1'b0;
    i1.out_ready = 1'b1;
    i1.in_b = bb[0]; i1.in_a = aa[0]; i1.in_valid = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
      if (adv) begin
        adv = 1'b0;
        if (k < 5) begin
          i1.in_b = bb[k];
          i1.in_a = aa[k];
        end else begin
          i1.in_valid = 1'b0;
        end
      end
      if (i1.in_valid === 1'b1 && i1.in_ready === 1'b1) begin
        q1.push_back(ref_mul(bb[k], aa[k]));
        if (last_t >= 0) chk("b2b_gap", 44'(cyc - last_t), 44'd10);
        last_t = cyc;
        k++;
        adv = 1'b1;
      end
      if (i1.out_valid === 1'b1) begin
        if (q1.size() > 0) e = q1.pop_front();
        else e = 44'h0;
        chk("b2b_product", i1.out_p, e);
        got++;
      end
      step();
    end
    i1.in_valid = 1'b0;
    i1.out_ready = 1'b0;
    chk("b2b_count", 44'(got), 44'd5);

    // Random operands on the G=2 and G=8 instances in lockstep.
    for (int j = 0; j < 1000; j++) begin
      int n;
      int nb2;
      int nb8;
      bit g2;
      bit g8;
      t  = $urandom;
      rb = t[27:0];
      t  = $urandom;
      ra = t[15:0];
      if (j % 100 == 0) begin rb = 28'h8000000; ra = 16'h8000; end
      if (j % 100 == 1) begin rb = 28'h8000000; ra = 16'h7FFF; end
      i2.in_b = rb; i2.in_a = ra; i2.in_valid = 1'b1;
      i8.in_b = rb; i8.in_a = ra; i8.in_valid = 1'b1;
      q2.push_back(ref_mul(rb, ra));
      q8.push_back(ref_mul(rb, ra));
      step();
      i2.in_valid = 1'b0;
      i8.in_valid = 1'b0;
      n = 0; nb2 = 0; nb8 = 0; g2 = 1'b0; g8 = 1'b0;
      while (!(g2 && g8) && n < 20) begin
        if (i2.busy === 1'b1) nb2++;
        if (i8.busy === 1'b1) nb8++;
        if (!g2 && i2.out_valid === 1'b1) begin
          if (q2.size() > 0) e = q2.pop_front();
          else e = 44'h0;
          chk("g2_product", i2.out_p, e);
          chk("g2_busy_cycles", 44'(nb2), 44'd4);
          g2 = 1'b1;
        end
        if (!g8 && i8.out_valid === 1'b1) begin
          if (q8.size() > 0) e = q8.pop_front();
          else e = 44'h0;
          chk("g8_product", i8.out_p, e);
          chk("g8_busy_cycles", 44'(nb8), 44'd1);
          g8 = 1'b1;
        end
        step();
        n++;
      end
      chk("rand_done", 44'({g2, g8}), 44'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
